// File: rtl/vigenere_decryption.sv
// ----------------------------------------------------------------------------
// vigenere_decryption
//
// Streaming Vigenere decryptor. A key of up to KEY_CHARS characters is loaded
// through a one-cycle LOAD state. Each accepted ciphertext character is then
// decrypted with the current key character. The result appears one cycle
// later on data_o/valid_o. The key index wraps at the latched key length.
// TERM_TOKEN ends a message: it restarts the key index and produces no output.
//
// Optional feature, selected by defining the macro VIGENERE_ALPHA_MOD_EN:
//   The design works in alphabet mode (D_WIDTH >= 7). Letters rotate mod 26
//   within their own case. Other characters pass through unchanged and do not
//   consume a key character.
//   With the macro undefined, the design decrypts as (c - k) mod 2^D_WIDTH on
//   every character.
//
// Parameters:
//   D_WIDTH    - character width in bits
//   KEY_CHARS  - maximum key length in characters
//   TERM_TOKEN - end-of-message token
//
// Ports:
//   clk      in   system clock, posedge
//   rst_n    in   synchronous active-low reset
//   key      in   key characters, char 0 in [D_WIDTH-1:0]
//   key_len  in   number of active key characters (0 -> 1, >KEY_CHARS -> KEY_CHARS)
//   key_load in   one-cycle request to latch key/key_len
//   data_i   in   encrypted character
//   valid_i  in   data_i qualifier (used only in RUN)
//   busy     out  high during the LOAD cycle
//   data_o   out  decrypted character (0 when valid_o is low)
//   valid_o  out  data_o qualifier
// ----------------------------------------------------------------------------
module vigenere_decryption #(
    parameter int unsigned        D_WIDTH    = 8,
    parameter int unsigned        KEY_CHARS  = 4,
    parameter logic [D_WIDTH-1:0] TERM_TOKEN = D_WIDTH'(8'hFA)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [KEY_CHARS*D_WIDTH-1:0]     key,
    input  logic [$clog2(KEY_CHARS+1)-1:0]   key_len,
    input  logic                             key_load,
    input  logic [D_WIDTH-1:0]               data_i,
    input  logic                             valid_i,
    output logic                             busy,
    output logic [D_WIDTH-1:0]               data_o,
    output logic                             valid_o
);

    localparam int unsigned LEN_W = $clog2(KEY_CHARS + 1);
    localparam int unsigned IDX_W = (KEY_CHARS > 1) ? $clog2(KEY_CHARS) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                         r_state, w_state_d;
    logic [KEY_CHARS*D_WIDTH-1:0]   r_key, w_key_d;
    logic [LEN_W-1:0]               r_key_len, w_key_len_d;
    logic [IDX_W-1:0]               r_idx, w_idx_d;
    logic                           r_valid, w_valid_d;
    logic [D_WIDTH-1:0]             r_data, w_data_d;

    logic [D_WIDTH-1:0]             w_keychar;
    logic [D_WIDTH-1:0]             w_dec;
    logic                           w_adv;

    // Current key character selected by the running index.
    always_comb begin
        w_keychar = '0;
        for (int i = 0; i < KEY_CHARS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_keychar = r_key[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

`ifdef VIGENERE_ALPHA_MOD_EN
    localparam logic [D_WIDTH-1:0] CH_UA = D_WIDTH'(65);
    localparam logic [D_WIDTH-1:0] CH_UZ = D_WIDTH'(90);
    localparam logic [D_WIDTH-1:0] CH_LA = D_WIDTH'(97);
    localparam logic [D_WIDTH-1:0] CH_LZ = D_WIDTH'(122);
    localparam logic [D_WIDTH-1:0] MOD26 = D_WIDTH'(26);

    logic [D_WIDTH-1:0] w_shift;
    logic [D_WIDTH-1:0] w_base;
    logic [D_WIDTH-1:0] w_rot;
    logic               w_is_upper;
    logic               w_is_lower;

    always_comb begin
        if (w_keychar >= CH_UA && w_keychar <= CH_UZ) begin
            w_shift = w_keychar - CH_UA;
        end else if (w_keychar >= CH_LA && w_keychar <= CH_LZ) begin
            w_shift = w_keychar - CH_LA;
        end else begin
            w_shift = w_keychar % MOD26;
        end

        w_is_upper = (data_i >= CH_UA) && (data_i <= CH_UZ);
        w_is_lower = (data_i >= CH_LA) && (data_i <= CH_LZ);
        w_base     = w_is_upper ? CH_UA : CH_LA;

        // Offset and shift are both below 26, so one conditional subtract
        // brings the sum back into range.
        w_rot = data_i - w_base + MOD26 - w_shift;
        if (w_rot >= MOD26) begin
            w_rot = w_rot - MOD26;
        end

        if (w_is_upper || w_is_lower) begin
            w_dec = w_rot + w_base;
            w_adv = 1'b1;
        end else begin
            w_dec = data_i;
            w_adv = 1'b0;
        end
    end
`else
    assign w_dec = data_i - w_keychar;
    assign w_adv = 1'b1;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_key_d     = r_key;
        w_key_len_d = r_key_len;
        w_idx_d     = r_idx;
        w_valid_d   = 1'b0;
        w_data_d    = '0;

        unique case (r_state)
            StIdle: begin
                if (key_load) begin
                    w_state_d = StLoad;
                end
            end
            StLoad: begin
                w_key_d = key;
                if (key_len == '0) begin
                    w_key_len_d = LEN_W'(1);
                end else if (key_len > LEN_W'(KEY_CHARS)) begin
                    w_key_len_d = LEN_W'(KEY_CHARS);
                end else begin
                    w_key_len_d = key_len;
                end
                w_idx_d   = '0;
                w_state_d = StRun;
            end
            StRun: begin
                // A character arriving with key_load still uses the old key.
                if (valid_i) begin
                    if (data_i == TERM_TOKEN) begin
                        w_idx_d = '0;
                    end else begin
                        w_valid_d = 1'b1;
                        w_data_d  = w_dec;
                        if (w_adv) begin
                            if (LEN_W'(r_idx) == r_key_len - LEN_W'(1)) begin
                                w_idx_d = '0;
                            end else begin
                                w_idx_d = r_idx + IDX_W'(1);
                            end
                        end
                    end
                end
                if (key_load) begin
                    w_state_d = StLoad;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_key     <= '0;
            r_key_len <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_key     <= w_key_d;
            r_key_len <= w_key_len_d;
            r_idx     <= w_idx_d;
            r_valid   <= w_valid_d;
            r_data    <= w_data_d;
        end
    end

    assign busy    = (r_state == StLoad);
    assign data_o  = r_data;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_vigenere_decryption.sv
// ----------------------------------------------------------------------------
// tb_vigenere_decryption
//
// Directed-vector bench for vigenere_decryption with default parameters.
// Alphabet-mode vectors are compiled only when VIGENERE_ALPHA_MOD_EN is
// defined. Otherwise the base-mode vectors run.
// ----------------------------------------------------------------------------
module tb_vigenere_decryption;

    logic        clk;
    logic        rst_n;
    logic [31:0] key;
    logic [2:0]  key_len;
    logic        key_load;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        busy;
    logic [7:0]  data_o;
    logic        valid_o;

    int n_checks;
    int n_fail;

    vigenere_decryption dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .key_len  (key_len),
        .key_load (key_load),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .busy     (busy),
        .data_o   (data_o),
        .valid_o  (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [31:0] k, input logic [2:0] len);
        valid_i  = 1'b0;
        key      = k;
        key_len  = len;
        key_load = 1'b1;
        tick();
        check("load_busy_hi", {31'd0, busy}, 32'd1);
        key_load = 1'b0;
        tick();
        check("load_busy_lo", {31'd0, busy}, 32'd0);
    endtask

    task automatic send(input string tag, input logic [7:0] d, input logic exp_v,
                        input logic [7:0] exp_d);
        data_i  = d;
        valid_i = 1'b1;
        tick();
        check({tag, "_v"}, {31'd0, valid_o}, {31'd0, exp_v});
        check({tag, "_d"}, {24'd0, data_o}, {24'd0, exp_d});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        key      = '0;
        key_len  = '0;
        key_load = 1'b0;
        data_i   = 8'h41;
        valid_i  = 1'b1;

        // Reset held for two cycles with valid_i high.
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_data", {24'd0, data_o}, 32'd0);

        // valid_i in IDLE is ignored.
        rst_n = 1'b1;
        tick();
        check("idle_valid", {31'd0, valid_o}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

`ifdef VIGENERE_ALPHA_MOD_EN
        // "KEY": RIJVS -> HELLO
        load_key({8'h00, 8'h59, 8'h45, 8'h4B}, 3'd3);
        send("a_r", 8'h52, 1'b1, 8'h48);
        send("a_i", 8'h49, 1'b1, 8'h45);
        send("a_j", 8'h4A, 1'b1, 8'h4C);
        send("a_v", 8'h56, 1'b1, 8'h4C);
        send("a_s", 8'h53, 1'b1, 8'h4F);
        // Key "BA": 'a'->'z', space passes and does not consume 'A', 'b'->'b'.
        load_key({16'h0000, 8'h41, 8'h42}, 3'd2);
        send("a_la", 8'h61, 1'b1, 8'h7A);
        send("a_sp", 8'h20, 1'b1, 8'h20);
        send("a_lb", 8'h62, 1'b1, 8'h62);
`else
        // Key 01 02 03, length 3.
        load_key({8'h00, 8'h03, 8'h02, 8'h01}, 3'd3);
        send("b_41", 8'h41, 1'b1, 8'h40);
        send("b_42", 8'h42, 1'b1, 8'h40);
        send("b_43", 8'h43, 1'b1, 8'h40);
        send("b_44", 8'h44, 1'b1, 8'h43);
        valid_i = 1'b0;
        tick();
        check("gap_valid", {31'd0, valid_o}, 32'd0);
        check("gap_data", {24'd0, data_o}, 32'd0);

        // TERM_TOKEN clears idx (idx was 1 here) and emits nothing.
        send("t_fa0", 8'hFA, 1'b0, 8'h00);
        send("t_41a", 8'h41, 1'b1, 8'h40);
        send("t_fa1", 8'hFA, 1'b0, 8'h00);
        send("t_41b", 8'h41, 1'b1, 8'h40);

        // key_len 0 latches as 1: key char 0x05 applied to every character.
        load_key({8'h09, 8'h09, 8'h09, 8'h05}, 3'd0);
        send("w_02", 8'h02, 1'b1, 8'hFD);
        send("w_10", 8'h10, 1'b1, 8'h0B);

        // key_len 7 latches as 4.
        load_key({8'h04, 8'h03, 8'h02, 8'h01}, 3'd7);
        send("c_0", 8'h10, 1'b1, 8'h0F);
        send("c_1", 8'h10, 1'b1, 8'h0E);
        send("c_2", 8'h10, 1'b1, 8'h0D);
        send("c_3", 8'h10, 1'b1, 8'h0C);
        send("c_4", 8'h10, 1'b1, 8'h0F);

        // Reload with valid_i: old key char idx1 (0x02) applies, then a
        // single busy cycle, then new key char 0 (0x10).
        key      = {8'h00, 8'h00, 8'h00, 8'h10};
        key_len  = 3'd1;
        key_load = 1'b1;
        data_i   = 8'h20;
        valid_i  = 1'b1;
        tick();
        check("rl_valid", {31'd0, valid_o}, 32'd1);
        check("rl_data", {24'd0, data_o}, 32'h1E);
        check("rl_busy", {31'd0, busy}, 32'd1);
        key_load = 1'b0;
        data_i   = 8'h30;
        tick();
        check("rl_load_valid", {31'd0, valid_o}, 32'd0);
        check("rl_busy_lo", {31'd0, busy}, 32'd0);
        tick();
        check("rl_new_valid", {31'd0, valid_o}, 32'd1);
        check("rl_new_data", {24'd0, data_o}, 32'h20);
`endif

        // Reset wins over key_load and valid_i; a fresh load is then needed.
        rst_n    = 1'b0;
        key_load = 1'b1;
        valid_i  = 1'b1;
        data_i   = 8'h41;
        tick();
        check("rst2_busy", {31'd0, busy}, 32'd0);
        check("rst2_valid", {31'd0, valid_o}, 32'd0);
        rst_n    = 1'b1;
        key_load = 1'b0;
        tick();
        check("rst2_idle_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("rst2_idle_valid2", {31'd0, valid_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
